// File: rtl/univ_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg -- shared definitions for the universal shift register.
//
// Purpose:
//   Holds the operation-select encodings driven on the Mode input and the
//   state encodings of the burst controller, so the register and anything
//   that drives it agree on a single definition.
//
// Contents:
//   mode_e  : 3-bit operation select (MODE_HOLD .. MODE_CLR)
//   state_e : controller state (ST_IDLE, ST_BURST)
// ---------------------------------------------------------------------------
package usr_pkg;

  // Operation select values. The burst mode is the only one that does not
  // complete in a single edge; every other mode acts on the edge that
  // samples it.
  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_BURST = 3'b110,
    MODE_CLR   = 3'b111
  } mode_e;

  // Controller state. BURST is occupied while a multi-cycle right shift is
  // running and is what the Busy output reports.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage : usr_pkg

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg -- parameterised universal shift register with burst mode.
//
// Purpose:
//   A WIDTH-bit register that can hold, shift left/right with serial input,
//   parallel load, rotate left/right, clear, or run a multi-cycle right-shift
//   burst of up to WIDTH positions. A two-state controller (IDLE/BURST)
//   sequences the burst; while it runs, only a clear request is honoured and
//   it aborts the burst.
//
// Parameters:
//   WIDTH     : register width in bits (2..64)
//   RESET_VAL : value forced into Q while Reset is high
//
// Ports:
//   Clk    in   1      rising-edge clock
//   Reset  in   1      asynchronous active-high reset
//   En     in   1      operation enable, Mode sampled when high in IDLE
//   Mode   in   3      operation select (usr_pkg::mode_e)
//   D      in   WIDTH  parallel load data
//   SinL   in   1      serial input entering the MSB on right shifts
//   SinR   in   1      serial input entering the LSB on left shifts
//   Cnt    in   clog2(WIDTH+1)  burst length, sampled on burst acceptance
//   Q      out  WIDTH  register contents
//   Qbar   out  WIDTH  bitwise complement of Q
//   SoutL  out  1      Q[WIDTH-1]
//   SoutR  out  1      Q[0]
//   Busy   out  1      high while a burst is running
// ---------------------------------------------------------------------------
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         En,
  input  logic [2:0]                   Mode,
  input  logic [WIDTH-1:0]             D,
  input  logic                         SinL,
  input  logic                         SinR,
  input  logic [$clog2(WIDTH+1)-1:0]   Cnt,
  output logic [WIDTH-1:0]             Q,
  output logic [WIDTH-1:0]             Qbar,
  output logic                         SoutL,
  output logic                         SoutR,
  output logic                         Busy
);

  // The burst counter must be able to hold the value WIDTH itself, hence
  // clog2(WIDTH+1) rather than clog2(WIDTH).
  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  state_e             state;
  state_e             state_nxt;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   q_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;

  // Candidate next values for every data-path operation. Computing them
  // once keeps the mode decode below a plain selection.
  logic [WIDTH-1:0]   shl_val;
  logic [WIDTH-1:0]   shr_val;
  logic [WIDTH-1:0]   rol_val;
  logic [WIDTH-1:0]   ror_val;
  logic [CNT_W-1:0]   burst_len;

  assign shl_val = {q_reg[WIDTH-2:0], SinR};
  assign shr_val = {SinL, q_reg[WIDTH-1:1]};
  assign rol_val = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign ror_val = {q_reg[0], q_reg[WIDTH-1:1]};

  // A request longer than the register is clamped: after WIDTH shifts every
  // original bit is gone, so further shifts would only be wasted cycles.
  assign burst_len = (Cnt > CNT_MAX) ? CNT_MAX : Cnt;

  // State, data and counter registers. Reset is asynchronous so Q reflects
  // RESET_VAL immediately, and any burst in flight is dropped.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      q_reg <= RESET_VAL;
      count <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      q_reg <= q_nxt;
      count <= count_nxt;
    end
  end

  // Next-state and data-path decode. In IDLE the sampled Mode acts on this
  // edge; the burst mode only arms the counter (Q untouched on the accepting
  // edge) and a zero-length burst is treated as a hold. In BURST every edge
  // shifts right and counts down, leaving on the edge that sees count==1,
  // unless a clear request arrives, which zeroes Q and aborts.
  always_comb begin
    state_nxt = state;
    q_nxt     = q_reg;
    count_nxt = count;

    case (state)
      ST_IDLE: begin
        if (En) begin
          case (Mode)
            MODE_HOLD:  q_nxt = q_reg;
            MODE_SHL:   q_nxt = shl_val;
            MODE_SHR:   q_nxt = shr_val;
            MODE_LOAD:  q_nxt = D;
            MODE_ROL:   q_nxt = rol_val;
            MODE_ROR:   q_nxt = ror_val;
            MODE_BURST: begin
              if (Cnt != CNT_ZERO) begin
                count_nxt = burst_len;
                state_nxt = ST_BURST;
              end
            end
            MODE_CLR:   q_nxt = '0;
            default:    q_nxt = q_reg;
          endcase
        end
      end

      ST_BURST: begin
        if (En && (Mode == MODE_CLR)) begin
          q_nxt     = '0;
          count_nxt = CNT_ZERO;
          state_nxt = ST_IDLE;
        end else begin
          q_nxt     = shr_val;
          count_nxt = count - CNT_ONE;
          if (count == CNT_ONE) begin
            state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        count_nxt = CNT_ZERO;
      end
    endcase
  end

  // Outputs are pure taps of the registered state, so Qbar and the serial
  // outputs follow Q without any added latency, including during reset.
  always_comb begin
    Q     = q_reg;
    Qbar  = ~q_reg;
    SoutL = q_reg[WIDTH-1];
    SoutR = q_reg[0];
    Busy  = (state == ST_BURST);
  end

endmodule : univ_shift_reg
